// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants.
//   REG_W    : default data width of a general-purpose register
//   NUM_GPR  : default number of general-purpose registers
//   REG_AW   : address width matching NUM_GPR
//   REG_ZERO : architectural hard-wired zero register address
package mips_pkg;

    localparam int unsigned REG_W   = 32;
    localparam int unsigned NUM_GPR = 32;
    localparam int unsigned REG_AW  = $clog2(NUM_GPR);
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// Register-file bus between ID (read/issue), WB (write) and the register file.
//   master : driven by the pipeline (addresses, enables, write data, issue)
//   slave  : the register file (returns read data, busy flags and stall)
interface mips_regfile_sb_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH    = REG_W,
    parameter int unsigned NUM_REGS = NUM_GPR,
    parameter int unsigned AW       = $clog2(NUM_REGS)
);

    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic             rden_a;
    logic             rden_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             issue_valid;
    logic [AW-1:0]    issue_dst;
    logic             busy_a;
    logic             busy_b;
    logic             stall;

    modport master (
        output raddr_a, raddr_b, rden_a, rden_b,
        output we, waddr, wdata, issue_valid, issue_dst,
        input  rdata_a, rdata_b, busy_a, busy_b, stall
    );

    modport slave (
        input  raddr_a, raddr_b, rden_a, rden_b,
        input  we, waddr, wdata, issue_valid, issue_dst,
        output rdata_a, rdata_b, busy_a, busy_b, stall
    );

endinterface

// File: rtl/mips_reg_word.sv
// Single WIDTH-bit storage register with load enable and asynchronous
// active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   en    : load d on the next rising edge
//   d     : data in
//   q     : stored value
module mips_reg_word #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// NUM_REGS x WIDTH register file, two combinational read ports, one write
// port, with a busy-bit scoreboard that flags RAW hazards to decode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears registers and busy bits)
//   bus   : slave side of mips_regfile_sb_if (read ports, WB write port,
//           issue port, busy_a/busy_b/stall hazard outputs)
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH    = REG_W,
    parameter int unsigned NUM_REGS = NUM_GPR,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_regfile_sb_if.slave  bus
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [WIDTH-1:0]    mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // True for an address that maps to real, writable storage.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if ((ZERO_REG != 0) && (g == 0)) begin : g_hard_zero
            assign mem[g] = '0;
        end else begin : g_word
            logic en;
            assign en = bus.we && addr_ok(bus.waddr) && (bus.waddr == AW'(g));
            mips_reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     (bus.wdata),
                .q     (mem[g])
            );
        end
    end

    // Issue has priority over WB clear: a newer producer for the same
    // register must keep it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (bus.issue_valid && addr_ok(bus.issue_dst) && (bus.issue_dst == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (bus.we && addr_ok(bus.waddr) && (bus.waddr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read ports are gated by rst_n so a bypassed wdata cannot leak out
    // while the array is held in reset.
    always_comb begin
        bus.rdata_a = '0;
        bus.busy_a  = 1'b0;
        if (rst_n && addr_ok(bus.raddr_a)) begin
            if ((BYPASS != 0) && bus.we && (bus.waddr == bus.raddr_a)) begin
                bus.rdata_a = bus.wdata;
            end else begin
                bus.rdata_a = mem[bus.raddr_a];
                bus.busy_a  = busy[bus.raddr_a];
            end
        end
    end

    always_comb begin
        bus.rdata_b = '0;
        bus.busy_b  = 1'b0;
        if (rst_n && addr_ok(bus.raddr_b)) begin
            if ((BYPASS != 0) && bus.we && (bus.waddr == bus.raddr_b)) begin
                bus.rdata_b = bus.wdata;
            end else begin
                bus.rdata_b = mem[bus.raddr_b];
                bus.busy_b  = busy[bus.raddr_b];
            end
        end
    end

    assign bus.stall = (bus.rden_a && bus.busy_a) || (bus.rden_b && bus.busy_b);

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed testbench for mips_regfile_sb: a vector table for the default
// 32x32 configuration plus hand sequences for reset, and a second instance
// (16-bit, 24 regs, no zero reg, no bypass) checked against a small model.
module tb_mips_regfile_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_regfile_sb_if #(.WIDTH(32), .NUM_REGS(32)) bus1 ();
    mips_regfile_sb_if #(.WIDTH(16), .NUM_REGS(24)) bus2 ();

    mips_regfile_sb #(.WIDTH(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );
    mips_regfile_sb #(.WIDTH(16), .NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  idst;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rden_a;
        logic        rden_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy_a;
        logic        exp_busy_b;
        logic        exp_stall;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[18];
    logic [15:0] model[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic iv, input logic [4:0] id,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic ea, input logic eb,
                                input logic [31:0] xa, input logic [31:0] xb,
                                input logic ba, input logic bb, input logic st);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.iv = iv; v.idst = id;
        v.ra = ra; v.rb = rb; v.rden_a = ea; v.rden_b = eb;
        v.exp_a = xa; v.exp_b = xb; v.exp_busy_a = ba; v.exp_busy_b = bb; v.exp_stall = st;
        return v;
    endfunction

    task automatic idle1();
        bus1.we = 0; bus1.waddr = '0; bus1.wdata = '0; bus1.issue_valid = 0; bus1.issue_dst = '0;
        bus1.raddr_a = '0; bus1.raddr_b = '0; bus1.rden_a = 0; bus1.rden_b = 0;
    endtask

    task automatic idle2();
        bus2.we = 0; bus2.waddr = '0; bus2.wdata = '0; bus2.issue_valid = 0; bus2.issue_dst = '0;
        bus2.raddr_a = '0; bus2.raddr_b = '0; bus2.rden_a = 0; bus2.rden_b = 0;
    endtask

    initial begin
        //        we wa  wdata         iv id  ra  rb  ea eb exp_a         exp_b         ba bb st
        vecs[0]  = mk(0, 0, 32'h0,        0, 0,  0,  5, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[1]  = mk(1, 7, 32'h12345678, 0, 0,  7,  1, 0, 0, 32'h12345678, 32'h0,        0, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 0,  7,  0, 0, 0, 32'h12345678, 32'h0,        0, 0, 0);
        vecs[3]  = mk(1, 0, 32'hFFFFFFFF, 1, 0,  0,  0, 1, 1, 32'h0,        32'h0,        0, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,        0, 0,  0,  0, 1, 1, 32'h0,        32'h0,        0, 0, 0);
        vecs[5]  = mk(0, 0, 32'h0,        1, 9,  9,  9, 0, 1, 32'h0,        32'h0,        0, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,        0, 0,  9,  9, 0, 1, 32'h0,        32'h0,        1, 1, 1);
        vecs[7]  = mk(0, 0, 32'h0,        0, 0,  9,  7, 1, 0, 32'h0,        32'h12345678, 1, 0, 1);
        vecs[8]  = mk(0, 0, 32'h0,        0, 0,  9,  9, 0, 0, 32'h0,        32'h0,        1, 1, 0);
        vecs[9]  = mk(1, 9, 32'hA5,       0, 0,  7,  9, 0, 1, 32'h12345678, 32'hA5,       0, 0, 0);
        vecs[10] = mk(0, 0, 32'h0,        0, 0,  9,  9, 1, 1, 32'hA5,       32'hA5,       0, 0, 0);
        vecs[11] = mk(0, 0, 32'h0,        1, 3,  3,  3, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[12] = mk(1, 3, 32'h33,       1, 3,  3,  3, 1, 0, 32'h33,       32'h33,       0, 0, 0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0,  3,  3, 1, 0, 32'h33,       32'h33,       1, 1, 1);
        vecs[14] = mk(1, 3, 32'h44,       0, 0,  3,  4, 1, 0, 32'h44,       32'h0,        0, 0, 0);
        vecs[15] = mk(0, 0, 32'h0,        0, 0,  3,  3, 1, 1, 32'h44,       32'h44,       0, 0, 0);
        vecs[16] = mk(1, 31, 32'hCAFEF00D, 1, 31, 31, 0, 0, 0, 32'hCAFEF00D, 32'h0,       0, 0, 0);
        vecs[17] = mk(0, 0, 32'h0,        0, 0,  31, 31, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 1);

        idle1();
        idle2();
        rst_n = 1'b0;
        #1;
        chk("reset rdata_a", bus1.rdata_a, 32'h0);
        chk("reset stall", {31'h0, bus1.stall}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            bus1.we = vecs[i].we; bus1.waddr = vecs[i].waddr; bus1.wdata = vecs[i].wdata;
            bus1.issue_valid = vecs[i].iv; bus1.issue_dst = vecs[i].idst;
            bus1.raddr_a = vecs[i].ra; bus1.raddr_b = vecs[i].rb;
            bus1.rden_a = vecs[i].rden_a; bus1.rden_b = vecs[i].rden_b;
            #1;
            chk($sformatf("v%0d rdata_a", i), bus1.rdata_a, vecs[i].exp_a);
            chk($sformatf("v%0d rdata_b", i), bus1.rdata_b, vecs[i].exp_b);
            chk($sformatf("v%0d busy_a", i), {31'h0, bus1.busy_a}, {31'h0, vecs[i].exp_busy_a});
            chk($sformatf("v%0d busy_b", i), {31'h0, bus1.busy_b}, {31'h0, vecs[i].exp_busy_b});
            chk($sformatf("v%0d stall", i), {31'h0, bus1.stall}, {31'h0, vecs[i].exp_stall});
            step();
        end
        idle1();

        // Mid-cycle asynchronous reset: r5 written, r31 still busy from the table.
        bus1.we = 1; bus1.waddr = 5; bus1.wdata = 32'hDEADBEEF;
        step();
        bus1.we = 0; bus1.raddr_a = 5; bus1.raddr_b = 31; bus1.rden_b = 1;
        #1;
        chk("pre-reset r5", bus1.rdata_a, 32'hDEADBEEF);
        chk("pre-reset busy r31", {31'h0, bus1.busy_b}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset r5", bus1.rdata_a, 32'h0);
        chk("async reset busy_b", {31'h0, bus1.busy_b}, 32'h0);
        chk("async reset stall", {31'h0, bus1.stall}, 32'h0);
        bus1.we = 1; bus1.waddr = 5; bus1.wdata = 32'h11111111;
        #1;
        chk("in-reset bypass blocked", bus1.rdata_a, 32'h0);
        step();
        bus1.we = 0;
        rst_n = 1'b1;
        #1;
        chk("post-reset r5", bus1.rdata_a, 32'h0);
        chk("post-reset busy r31", {31'h0, bus1.busy_b}, 32'h0);
        bus1.raddr_a = 9; bus1.raddr_b = 7;
        #1;
        chk("post-reset r9", bus1.rdata_a, 32'h0);
        chk("post-reset r7", bus1.rdata_b, 32'h0);
        idle1();
        step();

        // Second instance: 24 regs, 16 bits, r0 ordinary, no bypass.
        bus2.we = 1; bus2.waddr = 30; bus2.wdata = 16'hBEEF; bus2.raddr_a = 30;
        #1;
        chk("d2 oor same cycle", {16'h0, bus2.rdata_a}, 32'h0);
        step();
        bus2.we = 0;
        #1;
        chk("d2 oor next cycle", {16'h0, bus2.rdata_a}, 32'h0);
        bus2.issue_valid = 1; bus2.issue_dst = 30;
        step();
        bus2.issue_valid = 0; bus2.rden_a = 1;
        #1;
        chk("d2 oor busy", {31'h0, bus2.busy_a}, 32'h0);
        chk("d2 oor stall", {31'h0, bus2.stall}, 32'h0);

        bus2.we = 1; bus2.waddr = 0; bus2.wdata = 16'h1234; bus2.raddr_a = 0;
        #1;
        chk("d2 r0 no bypass", {16'h0, bus2.rdata_a}, 32'h0);
        step();
        bus2.we = 0;
        #1;
        chk("d2 r0 written", {16'h0, bus2.rdata_a}, 32'h1234);
        bus2.issue_valid = 1; bus2.issue_dst = 0;
        step();
        bus2.issue_valid = 0;
        #1;
        chk("d2 r0 busy", {31'h0, bus2.busy_a}, 32'h1);
        chk("d2 r0 stall", {31'h0, bus2.stall}, 32'h1);
        bus2.we = 1; bus2.waddr = 0; bus2.wdata = 16'h5678;
        #1;
        chk("d2 busy held w/o bypass", {31'h0, bus2.busy_a}, 32'h1);
        chk("d2 old data w/o bypass", {16'h0, bus2.rdata_a}, 32'h1234);
        step();
        bus2.we = 0;
        #1;
        chk("d2 busy cleared", {31'h0, bus2.busy_a}, 32'h0);
        chk("d2 new data", {16'h0, bus2.rdata_a}, 32'h5678);
        idle2();

        for (int i = 0; i < 24; i++) model[i] = '0;
        model[0] = 16'h5678;
        for (int i = 0; i < 30; i++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            logic [4:0] rb;
            logic [15:0] wd;
            wa = 5'($urandom_range(0, 23));
            wd = 16'($urandom);
            bus2.we = 1; bus2.waddr = wa; bus2.wdata = wd;
            step();
            model[wa] = wd;
            bus2.we = 0;
            ra = 5'($urandom_range(0, 31));
            rb = (i % 2 == 0) ? wa : 5'($urandom_range(0, 31));
            bus2.raddr_a = ra; bus2.raddr_b = rb;
            #1;
            chk($sformatf("d2 rnd%0d a[%0d]", i, ra), {16'h0, bus2.rdata_a},
                {16'h0, (ra < 24) ? model[ra] : 16'h0});
            chk($sformatf("d2 rnd%0d b[%0d]", i, rb), {16'h0, bus2.rdata_b},
                {16'h0, (rb < 24) ? model[rb] : 16'h0});
        end
        idle2();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
